wb_stage: RTL and testbench

//  Write-back stage of the 5-stage pipelined RV32I core: the producer end of the register-file write port that ID consumes.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage_load_align.sv | 52 +++++
 rtl/wb_stage.sv | 153 +++++++++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the write-back stage.
//  - opcode constants for every instruction class that writes rd
//  - load func3 encodings
//  - write-back FSM state enum
//  - is_writer(): true for opcodes whose result lands in the register file
package riscv_pkg;

  localparam logic [6:0] OP_I1  = 7'b0010011;  // OP-IMM
  localparam logic [6:0] OP_I2  = 7'b0000011;  // LOAD
  localparam logic [6:0] OP_R   = 7'b0110011;  // OP
  localparam logic [6:0] OP_J   = 7'b1101111;  // JAL
  localparam logic [6:0] OP_JR  = 7'b1100111;  // JALR
  localparam logic [6:0] OP_U   = 7'b0110111;  // LUI
  localparam logic [6:0] OP_UPC = 7'b0010111;  // AUIPC

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_RUN,
    WB_WAIT_MEM
  } wb_state_e;

  function automatic logic is_writer(input logic [6:0] op);
    logic w;
    case (op)
      OP_I1, OP_I2, OP_R, OP_J, OP_JR, OP_U, OP_UPC: w = 1'b1;
      default:                                       w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB retire bus plus the WB -> ID register-file write port.
//  master: the pipeline side (MEM drives the retiring instruction, ID
//          consumes RegWrite/rd_WB/Data_WB)
//  slave : wb_stage
//  in_valid/in_ready       handshake, transfer = in_valid & in_ready
//  opcode/func3/rd         decoded fields of the retiring instruction
//  alu_result/PC           EX result (load address for loads) and PC
//  mem_rdata/mem_rvalid    data-memory read response
//  RegWrite/rd_WB/Data_WB  register-file write port (one-cycle pulse)
//  mem_err                 load error / timeout pulse
//  retire_count            instructions retired since reset
interface wb_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [4:0]       rd;
  logic [31:0]      alu_result;
  logic [31:0]      PC;
  logic [31:0]      mem_rdata;
  logic             mem_rvalid;
  logic             RegWrite;
  logic [4:0]       rd_WB;
  logic [31:0]      Data_WB;
  logic             mem_err;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output in_valid, opcode, func3, rd, alu_result, PC, mem_rdata, mem_rvalid,
    input  in_ready, RegWrite, rd_WB, Data_WB, mem_err, retire_count
  );

  modport slave (
    input  in_valid, opcode, func3, rd, alu_result, PC, mem_rdata, mem_rvalid,
    output in_ready, RegWrite, rd_WB, Data_WB, mem_err, retire_count
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load formatter.
//  func3     in  3   load width/sign encoding
//  offset    in  2   byte offset within the aligned word
//  mem_rdata in  32  aligned memory word
//  data      out 32  extracted, sign/zero-extended value
//  err       out 1   misaligned access or non-load func3
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (func3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = offset[0];
      end
      F3_LW: begin
        data = mem_rdata;
        err  = (offset != 2'd0);
      end
      F3_LBU: data = {24'd0, byte_sel};
      F3_LHU: begin
        data = {16'd0, half_sel};
        err  = offset[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage RV32I pipeline.
//  clk   in  clock, all state on rising edge
//  rst   in  asynchronous, active-low reset
//  bus   slave side of wb_stage_if (retire handshake from MEM, register
//        write port to ID, mem_err pulse, retire_count)
// Retires one instruction per cycle. Loads whose data is not yet valid park
// in WAIT_MEM (in_ready low) until mem_rvalid or MEM_TIMEOUT cycles elapse.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  wb_stage_if.slave  bus
);

  localparam int unsigned     TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  wb_state_e        state, state_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [4:0]       lat_rd, lat_rd_nxt;
  logic [2:0]       lat_f3, lat_f3_nxt;
  logic [1:0]       lat_off, lat_off_nxt;

  logic             reg_write, reg_write_nxt;
  logic             mem_err, mem_err_nxt;
  logic [4:0]       rd_wb, rd_wb_nxt;
  logic [31:0]      data_wb, data_wb_nxt;
  logic [CNT_W-1:0] retire_cnt;
  logic             retire;

  logic [2:0]       al_f3;
  logic [1:0]       al_off;
  logic [31:0]      al_data;
  logic             al_err;

  // One formatter serves both the same-cycle load and the parked load:
  // in WAIT_MEM the incoming bus fields are ignored, so the latched
  // func3/offset are steered in instead.
  assign al_f3  = (state == WB_WAIT_MEM) ? lat_f3  : bus.func3;
  assign al_off = (state == WB_WAIT_MEM) ? lat_off : bus.alu_result[1:0];

  load_align u_load_align (
    .func3     (al_f3),
    .offset    (al_off),
    .mem_rdata (bus.mem_rdata),
    .data      (al_data),
    .err       (al_err)
  );

  assign bus.in_ready     = (state == WB_RUN);
  assign bus.RegWrite     = reg_write;
  assign bus.rd_WB        = rd_wb;
  assign bus.Data_WB      = data_wb;
  assign bus.mem_err      = mem_err;
  assign bus.retire_count = retire_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WB_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    to_cnt_nxt    = to_cnt;
    lat_rd_nxt    = lat_rd;
    lat_f3_nxt    = lat_f3;
    lat_off_nxt   = lat_off;
    retire        = 1'b0;
    reg_write_nxt = 1'b0;
    mem_err_nxt   = 1'b0;
    rd_wb_nxt     = rd_wb;
    data_wb_nxt   = data_wb;

    case (state)
      WB_RUN: begin
        if (bus.in_valid) begin
          if (bus.opcode == OP_I2) begin
            if (al_err) begin
              retire      = 1'b1;
              mem_err_nxt = 1'b1;
              rd_wb_nxt   = bus.rd;
              data_wb_nxt = al_data;
            end else if (bus.mem_rvalid) begin
              retire        = 1'b1;
              reg_write_nxt = (bus.rd != 5'd0);
              rd_wb_nxt     = bus.rd;
              data_wb_nxt   = al_data;
            end else begin
              state_nxt   = WB_WAIT_MEM;
              to_cnt_nxt  = '0;
              lat_rd_nxt  = bus.rd;
              lat_f3_nxt  = bus.func3;
              lat_off_nxt = bus.alu_result[1:0];
            end
          end else begin
            retire        = 1'b1;
            reg_write_nxt = is_writer(bus.opcode) && (bus.rd != 5'd0);
            rd_wb_nxt     = bus.rd;
            data_wb_nxt   = (bus.opcode == OP_J || bus.opcode == OP_JR) ?
                            bus.PC + 32'd4 : bus.alu_result;
          end
        end
      end

      WB_WAIT_MEM: begin
        to_cnt_nxt = to_cnt + TO_W'(1);
        if (bus.mem_rvalid) begin
          state_nxt     = WB_RUN;
          retire        = 1'b1;
          reg_write_nxt = (lat_rd != 5'd0);
          rd_wb_nxt     = lat_rd;
          data_wb_nxt   = al_data;
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = WB_RUN;
          retire      = 1'b1;
          mem_err_nxt = 1'b1;
          rd_wb_nxt   = lat_rd;
        end
      end

      default: state_nxt = WB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt     <= '0;
      lat_rd     <= '0;
      lat_f3     <= '0;
      lat_off    <= '0;
      reg_write  <= 1'b0;
      mem_err    <= 1'b0;
      rd_wb      <= '0;
      data_wb    <= '0;
      retire_cnt <= '0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      lat_rd    <= lat_rd_nxt;
      lat_f3    <= lat_f3_nxt;
      lat_off   <= lat_off_nxt;
      reg_write <= reg_write_nxt;
      mem_err   <= mem_err_nxt;
      rd_wb     <= rd_wb_nxt;
      data_wb   <= data_wb_nxt;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_stage_if #(.CNT_W(32)) bus ();

  wb_stage #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.opcode     = 7'd0;
    bus.func3      = 3'd0;
    bus.rd         = 5'd0;
    bus.alu_result = 32'd0;
    bus.PC         = 32'd0;
    bus.mem_rdata  = 32'd0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                      input logic [31:0] alu, input logic [31:0] pc,
                      input logic [31:0] rdata, input logic rv);
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.func3      = f3;
    bus.rd         = r;
    bus.alu_result = alu;
    bus.PC         = pc;
    bus.mem_rdata  = rdata;
    bus.mem_rvalid = rv;
    cyc();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b0;
    #2;
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_rd_wb",    32'(bus.rd_WB),    32'd0);
    chk("rst_data_wb",  bus.Data_WB,       32'd0);
    chk("rst_mem_err",  32'(bus.mem_err),  32'd0);
    chk("rst_count",    bus.retire_count,  32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // R-type
    send(7'b0110011, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1'b0);
    chk("r_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("r_rd_wb",    32'(bus.rd_WB),    32'd5);
    chk("r_data",     bus.Data_WB,       32'h0000_1234);
    chk("r_count",    bus.retire_count,  32'd1);
    cyc();
    chk("r_pulse_end", 32'(bus.RegWrite), 32'd0);

    // LB / LBU / LHU with same-cycle rvalid
    send(7'b0000011, 3'b000, 5'd7, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lb_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("lb_rd_wb",    32'(bus.rd_WB),    32'd7);
    chk("lb_data",     bus.Data_WB,       32'hFFFF_FF80);
    chk("lb_count",    bus.retire_count,  32'd2);
    send(7'b0000011, 3'b100, 5'd8, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lbu_data",    bus.Data_WB,       32'h0000_0080);
    chk("lbu_rd_wb",   32'(bus.rd_WB),    32'd8);
    send(7'b0000011, 3'b101, 5'd8, 32'h0000_1002, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lhu_data",    bus.Data_WB,       32'h0000_80FF);
    chk("lhu_count",   bus.retire_count,  32'd4);

    // LW, rvalid 4 cycles after transfer; in_valid during the wait is ignored
    send(7'b0000011, 3'b010, 5'd9, 32'h0000_2000, 32'h0, 32'h0, 1'b0);
    chk("lw_wait1_ready", 32'(bus.in_ready), 32'd0);
    chk("lw_wait1_wr",    32'(bus.RegWrite), 32'd0);
    bus.in_valid   = 1'b1;
    bus.opcode     = 7'b0110011;
    bus.rd         = 5'd3;
    bus.alu_result = 32'h5555_5555;
    cyc();
    chk("lw_wait2_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk("lw_wait3_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk("lw_wait4_ready", 32'(bus.in_ready), 32'd0);
    chk("lw_wait_count",  bus.retire_count,  32'd4);
    idle();
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.mem_rvalid = 1'b1;
    cyc();
    idle();
    chk("lw_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("lw_rd_wb",    32'(bus.rd_WB),    32'd9);
    chk("lw_data",     bus.Data_WB,       32'hDEAD_BEEF);
    chk("lw_ready",    32'(bus.in_ready), 32'd1);
    chk("lw_count",    bus.retire_count,  32'd5);
    cyc();
    chk("lw_no_ghost", bus.retire_count,  32'd5);

    // Misaligned LH and illegal load func3
    send(7'b0000011, 3'b001, 5'd10, 32'h0000_3001, 32'h0, 32'h1234_5678, 1'b1);
    chk("lh_mis_err",   32'(bus.mem_err),  32'd1);
    chk("lh_mis_wr",    32'(bus.RegWrite), 32'd0);
    chk("lh_mis_ready", 32'(bus.in_ready), 32'd1);
    chk("lh_mis_count", bus.retire_count,  32'd6);
    send(7'b0000011, 3'b011, 5'd10, 32'h0000_3000, 32'h0, 32'h0, 1'b0);
    chk("ld_ill_err",   32'(bus.mem_err),  32'd1);
    chk("ld_ill_count", bus.retire_count,  32'd7);
    cyc();
    chk("err_pulse_end", 32'(bus.mem_err), 32'd0);

    // LW timeout after 16 wait cycles
    send(7'b0000011, 3'b010, 5'd11, 32'h0000_4000, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk("to_wait_ready", 32'(bus.in_ready), 32'd0);
      chk("to_wait_err",   32'(bus.mem_err),  32'd0);
      cyc();
    end
    chk("to_last_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk("to_err",   32'(bus.mem_err),  32'd1);
    chk("to_wr",    32'(bus.RegWrite), 32'd0);
    chk("to_ready", 32'(bus.in_ready), 32'd1);
    chk("to_count", bus.retire_count,  32'd8);

    // rvalid on the timeout cycle: data wins
    send(7'b0000011, 3'b010, 5'd12, 32'h0000_5000, 32'h0, 32'h0, 1'b0);
    repeat (15) cyc();
    chk("tie_ready", 32'(bus.in_ready), 32'd0);
    bus.mem_rdata  = 32'h0BAD_F00D;
    bus.mem_rvalid = 1'b1;
    cyc();
    idle();
    chk("tie_wr",    32'(bus.RegWrite), 32'd1);
    chk("tie_err",   32'(bus.mem_err),  32'd0);
    chk("tie_data",  bus.Data_WB,       32'h0BAD_F00D);
    chk("tie_count", bus.retire_count,  32'd9);

    // rd=0 ADDI, SW, JAL, JALR wrap, LUI
    send(7'b0010011, 3'd0, 5'd0, 32'h0000_0055, 32'h0, 32'h0, 1'b0);
    chk("addi_x0_wr",  32'(bus.RegWrite), 32'd0);
    chk("addi_count",  bus.retire_count,  32'd10);
    send(7'b0100011, 3'b010, 5'd4, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
    chk("sw_wr",       32'(bus.RegWrite), 32'd0);
    chk("sw_count",    bus.retire_count,  32'd11);
    send(7'b1101111, 3'd0, 5'd1, 32'h0000_0999, 32'h0000_0100, 32'h0, 1'b0);
    chk("jal_wr",      32'(bus.RegWrite), 32'd1);
    chk("jal_rd_wb",   32'(bus.rd_WB),    32'd1);
    chk("jal_data",    bus.Data_WB,       32'h0000_0104);
    chk("jal_count",   bus.retire_count,  32'd12);
    send(7'b1100111, 3'd0, 5'd2, 32'h0000_0777, 32'hFFFF_FFFC, 32'h0, 1'b0);
    chk("jalr_wrap",   bus.Data_WB,       32'h0000_0000);
    send(7'b0110111, 3'd0, 5'd3, 32'hABCD_E000, 32'h0000_0200, 32'h0, 1'b0);
    chk("lui_data",    bus.Data_WB,       32'hABCD_E000);
    chk("lui_count",   bus.retire_count,  32'd14);

    // Reset while a load is parked
    send(7'b0000011, 3'b010, 5'd13, 32'h0000_6000, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("prerst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_data",  bus.Data_WB,       32'd0);
    chk("mrst_rd_wb", 32'(bus.rd_WB),    32'd0);
    chk("mrst_count", bus.retire_count,  32'd0);
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    rst = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    bus.mem_rvalid = 1'b1;
    cyc();
    idle();
    chk("postrst_wr",    32'(bus.RegWrite), 32'd0);
    chk("postrst_data",  bus.Data_WB,       32'd0);
    chk("postrst_count", bus.retire_count,  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
